// File: rtl/sobel_grad_dir_pkg.sv
// Shared types and constants for the Sobel gradient/direction stage and the NMS stage.
// Direction codes select which neighbour pair the non-max-suppression stage compares.
package sobel_grad_dir_pkg;

    localparam int unsigned PIX_W  = 8;
    localparam int unsigned GRAD_W = 11;
    localparam int unsigned PROD_W = 13;

    localparam logic [PIX_W-1:0] DIR_E     = 8'd0;
    localparam logic [PIX_W-1:0] DIR_NE_SE = 8'd128;
    localparam logic [PIX_W-1:0] DIR_N     = 8'd192;
    localparam logic [PIX_W-1:0] DIR_NE_SW = 8'd255;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // One window row: west byte in the MSBs, east byte in the LSBs.
    typedef struct packed {
        logic [PIX_W-1:0] w;
        logic [PIX_W-1:0] c;
        logic [PIX_W-1:0] e;
    } row_t;

    function automatic logic signed [GRAD_W-1:0] ext(input logic [PIX_W-1:0] p);
        return $signed({3'b000, p});
    endfunction

endpackage

// File: rtl/sobel_kernel3x3.sv
// Stage 1: registered Sobel Gx/Gy of a 3x3 window; 11 signed bits hold the full +/-1020 range.
module sobel_kernel3x3
    import sobel_grad_dir_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  row_t                     row_a,
    input  row_t                     row_b,
    input  row_t                     row_c,
    output logic signed [GRAD_W-1:0] gx,
    output logic signed [GRAD_W-1:0] gy,
    output logic                     valid
);

    logic signed [GRAD_W-1:0] gx_c;
    logic signed [GRAD_W-1:0] gy_c;

    always_comb begin
        gx_c = (ext(row_a.e) - ext(row_a.w))
             + ((ext(row_b.e) - ext(row_b.w)) <<< 1)
             + (ext(row_c.e) - ext(row_c.w));
        gy_c = (ext(row_c.w) - ext(row_a.w))
             + ((ext(row_c.c) - ext(row_a.c)) <<< 1)
             + (ext(row_c.e) - ext(row_a.e));
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            gx    <= '0;
            gy    <= '0;
            valid <= 1'b0;
        end else begin
            valid <= in_valid;
            if (in_valid) begin
                gx <= gx_c;
                gy <= gy_c;
            end
        end
    end

endmodule

// File: rtl/sobel_grad_dir.sv
// Sobel magnitude and quantised direction for one frame pass: pass FSM, pixel counter,
// stage 2 (abs values, compare products) and stage 3 (output registers).
module sobel_grad_dir
    import sobel_grad_dir_pkg::*;
#(
    parameter int unsigned STARTADDRESS = 770,
    parameter int unsigned ENDADDRESS   = 1048576,
    parameter int unsigned PICW         = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             startEn,
    input  logic             inValid,
    input  logic [23:0]      pixHoldOutA,
    input  logic [23:0]      pixHoldOutB,
    input  logic [23:0]      pixHoldOutC,
    output logic [PIX_W-1:0] cannyOut,
    output logic [PIX_W-1:0] dirOut,
    output logic             outValid,
    output logic             busy,
    output logic             done
);

    localparam logic [PICW-1:0] LAST_PIX = PICW'(ENDADDRESS - 1);

    state_t          state, state_next;
    logic [PICW-1:0] pix_cnt, pix_cnt_next;
    logic [1:0]      drain_cnt, drain_cnt_next;
    logic            accept_c;

    logic signed [GRAD_W-1:0] gx, gy;
    logic                     v1;

    // Pass control: counter walks STARTADDRESS..ENDADDRESS-1, then 3 drain cycles cover the pipe.
    always_comb begin
        state_next     = state;
        pix_cnt_next   = pix_cnt;
        drain_cnt_next = drain_cnt;
        accept_c       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (startEn) begin
                    state_next   = ST_RUN;
                    pix_cnt_next = PICW'(STARTADDRESS);
                end
            end
            ST_RUN: begin
                if (inValid) begin
                    accept_c     = 1'b1;
                    pix_cnt_next = pix_cnt + PICW'(1);
                    if (pix_cnt == LAST_PIX) begin
                        state_next     = ST_DRAIN;
                        drain_cnt_next = 2'd0;
                    end
                end
            end
            ST_DRAIN: begin
                if (drain_cnt == 2'd2) begin
                    state_next = ST_DONE;
                end else begin
                    drain_cnt_next = drain_cnt + 2'd1;
                end
            end
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= ST_IDLE;
            pix_cnt   <= '0;
            drain_cnt <= 2'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_next;
            pix_cnt   <= pix_cnt_next;
            drain_cnt <= drain_cnt_next;
            busy      <= (state_next == ST_RUN) || (state_next == ST_DRAIN);
            done      <= (state_next == ST_DONE);
        end
    end

    sobel_kernel3x3 u_kernel (
        .clk      (clk),
        .reset    (reset),
        .in_valid (accept_c),
        .row_a    (pixHoldOutA),
        .row_b    (pixHoldOutB),
        .row_c    (pixHoldOutC),
        .gx       (gx),
        .gy       (gy),
        .valid    (v1)
    );

    logic [GRAD_W-1:0] ax_c, ay_c;
    logic [PROD_W-1:0] p5ax, p5ay, p2ax, p2ay;
    logic [PIX_W-1:0]  mag;
    logic              same_sign;
    logic              v2;

    assign ax_c = gx[GRAD_W-1] ? $unsigned(-gx) : $unsigned(gx);
    assign ay_c = gy[GRAD_W-1] ? $unsigned(-gy) : $unsigned(gy);

    // Stage 2: 5*a vs 2*b products give the tan(22.5)/tan(67.5) sector tests without a divider.
    always_ff @(posedge clk) begin
        if (!reset) begin
            p5ax      <= '0;
            p5ay      <= '0;
            p2ax      <= '0;
            p2ay      <= '0;
            mag       <= '0;
            same_sign <= 1'b0;
            v2        <= 1'b0;
        end else begin
            v2        <= v1;
            p5ax      <= (PROD_W'(ax_c) << 2) + PROD_W'(ax_c);
            p5ay      <= (PROD_W'(ay_c) << 2) + PROD_W'(ay_c);
            p2ax      <= PROD_W'(ax_c) << 1;
            p2ay      <= PROD_W'(ay_c) << 1;
            mag       <= PIX_W'((ax_c + ay_c) >> 3);
            same_sign <= (gx[GRAD_W-1] == gy[GRAD_W-1]);
        end
    end

    logic [PIX_W-1:0] dir_c;

    always_comb begin
        dir_c = DIR_E;
        if (p5ay <= p2ax) begin
            dir_c = DIR_E;
        end else if (p5ax <= p2ay) begin
            dir_c = DIR_N;
        end else if (same_sign) begin
            dir_c = DIR_NE_SE;
        end else begin
            dir_c = DIR_NE_SW;
        end
    end

    // Stage 3: outputs hold their last value across gaps.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cannyOut <= '0;
            dirOut   <= '0;
            outValid <= 1'b0;
        end else begin
            outValid <= v2;
            if (v2) begin
                cannyOut <= mag;
                dirOut   <= dir_c;
            end
        end
    end

endmodule
